// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between a mode-0 controller (master) and the register-file target (slave).
interface spi_slave_regfile_if;
    logic       sclk_i;
    logic       mosi_i;
    logic [3:0] cs_i;
    logic       miso_o;
    logic       miso_oe_o;

    modport master (
        output sclk_i,
        output mosi_i,
        output cs_i,
        input  miso_o,
        input  miso_oe_o
    );

    modport slave (
        input  sclk_i,
        input  mosi_i,
        input  cs_i,
        output miso_o,
        output miso_oe_o
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target: 16-bit frames (command/address byte + data byte) into a byte register file.
// Optional burst mode (address auto-increment across data bytes) is enabled by SPI_SLV_AUTOINC_EN.
module spi_slave_regfile #(
    parameter int DEPTH  = 128,
    parameter int CS_IDX = 0
) (
    input  logic               pclk_i,
    input  logic               prst_i,
    spi_slave_regfile_if.slave spi,
    output logic               wr_valid_o,
    output logic [6:0]         wr_addr_o,
    output logic [7:0]         wr_data_o,
    output logic               frame_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef SPI_SLV_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    state_t state, state_d;

    logic [1:0]    sclk_sync, mosi_sync, cs_sync;
    logic          sclk_prev, cs_prev, mosi_q;
    logic          sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [2:0]    bit_cnt;
    logic [6:0]    shift_in;
    logic [6:0]    shift_out;
    logic          is_write;
    logic          byte_seen;
    logic          load_pending;
    logic [AW-1:0] addr;
    logic          miso_q, miso_oe_q;
    logic [7:0]    mem [DEPTH];

    logic [7:0]    in_byte;
    logic          shift_rise, shift_fall, cmd_done, data_done, abort;
    logic          cs_unused;

    assign cs_unused     = ^spi.cs_i;
    assign spi.miso_o    = miso_q;
    assign spi.miso_oe_o = miso_oe_q;

    // Pins are resynchronised, then edges become registered one-cycle strobes (3 cycles pin-to-strobe).
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
            mosi_q    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.sclk_i};
            mosi_sync <= {mosi_sync[0], spi.mosi_i};
            cs_sync   <= {cs_sync[0], spi.cs_i[CS_IDX]};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
            mosi_q    <= mosi_sync[1];
            sclk_rise <= sclk_sync[1] & ~sclk_prev;
            sclk_fall <= ~sclk_sync[1] & sclk_prev;
            cs_rise   <= cs_sync[1] & ~cs_prev;
            cs_fall   <= ~cs_sync[1] & cs_prev;
        end
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // A deselect always wins, even against an SCLK rise in the same cycle.
    always_comb begin
        state_d = state;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall)   state_d = CMD;
                CMD:     if (cmd_done)  state_d = DATA;
                DATA:    if (data_done) state_d = AUTOINC ? DATA : CMD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_byte    = {shift_in, mosi_q};
        shift_rise = sclk_rise && !cs_rise && (state != IDLE);
        shift_fall = sclk_fall && !cs_rise && (state == DATA) && (bit_cnt != 3'd0) && !is_write;
        cmd_done   = shift_rise && (state == CMD)  && (bit_cnt == 3'd7);
        data_done  = shift_rise && (state == DATA) && (bit_cnt == 3'd7);
        abort      = cs_rise && (state != IDLE) &&
                     ((bit_cnt != 3'd0) || ((state == DATA) && !byte_seen));
    end

    // Read data is fetched the cycle after the address is known, so later assignments here win.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            bit_cnt      <= '0;
            shift_in     <= '0;
            shift_out    <= '0;
            is_write     <= 1'b0;
            byte_seen    <= 1'b0;
            load_pending <= 1'b0;
            addr         <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            wr_valid_o   <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            frame_err_o  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            if (cs_rise) begin
                miso_oe_q    <= 1'b0;
                miso_q       <= 1'b0;
                bit_cnt      <= '0;
                load_pending <= 1'b0;
                frame_err_o  <= abort;
            end else begin
                if ((state == IDLE) && cs_fall) begin
                    bit_cnt   <= '0;
                    miso_oe_q <= 1'b1;
                    miso_q    <= 1'b0;
                end
                if (load_pending) begin
                    shift_out    <= mem[addr][6:0];
                    miso_q       <= mem[addr][7];
                    load_pending <= 1'b0;
                end else if (shift_fall) begin
                    shift_out <= {shift_out[5:0], 1'b0};
                    miso_q    <= shift_out[6];
                end
                if (shift_rise) begin
                    shift_in <= in_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (cmd_done) begin
                    is_write     <= in_byte[7];
                    addr         <= in_byte[AW-1:0];
                    byte_seen    <= 1'b0;
                    load_pending <= !in_byte[7];
                end
                if (data_done) begin
                    byte_seen <= 1'b1;
                    miso_q    <= 1'b0;
                    if (is_write) begin
                        mem[addr]  <= in_byte;
                        wr_valid_o <= 1'b1;
                        wr_addr_o  <= 7'(addr);
                        wr_data_o  <= in_byte;
                    end
                    if (AUTOINC) begin
                        addr         <= addr + AW'(1);
                        load_pending <= !is_write;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: table-driven 16-bit frames, then abort, burst and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_spi_slave_regfile;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [3:0] cs;
        bit         sel;
        bit         is_wr;
        bit         chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    logic       pclk_i = 1'b0;
    logic       prst_i;
    logic       wr_valid_o;
    logic [6:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       frame_err_o;

    spi_slave_regfile_if spi ();

    spi_slave_regfile #(
        .DEPTH (128),
        .CS_IDX(0)
    ) dut (
        .pclk_i     (pclk_i),
        .prst_i     (prst_i),
        .spi        (spi),
        .wr_valid_o (wr_valid_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .frame_err_o(frame_err_o)
    );

    always #5 pclk_i = ~pclk_i;

    wr_t        exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    int         last_rise_cycle = 0;
    int         wr_count = 0;
    int         err_count = 0;
    int         wr0, err0;
    logic [7:0] tx_buf [4];
    logic [7:0] rx_buf [4];
    logic       oe_during;
    logic       last_miso;
    vec_t       vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expectWrite(input logic [6:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Master model: MOSI changes on SCLK low, MISO sampled just before each rise; SPI period is 16 pclk.
    task automatic applyStimulus(input int n_bits, input logic [3:0] cs_val, input bit keep_sel);
        @(negedge pclk_i);
        spi.cs_i = cs_val;
        repeat (8) @(negedge pclk_i);
        oe_during = spi.miso_oe_o;
        for (int i = 0; i < n_bits; i++) begin
            spi.mosi_i = tx_buf[i / 8][7 - (i % 8)];
            repeat (8) @(negedge pclk_i);
            rx_buf[i / 8][7 - (i % 8)] = spi.miso_o;
            spi.sclk_i      = 1'b1;
            last_rise_cycle = cycle;
            repeat (8) @(negedge pclk_i);
            spi.sclk_i = 1'b0;
        end
        repeat (8) @(negedge pclk_i);
        last_miso = spi.miso_o;
        if (!keep_sel) begin
            spi.cs_i = 4'hF;
            repeat (12) @(negedge pclk_i);
        end
    endtask

    task automatic writeFrame(input string name, input logic [6:0] a, input logic [7:0] d);
        wr0 = wr_count;
        expectWrite(a, d);
        tx_buf[0] = {1'b1, a};
        tx_buf[1] = d;
        applyStimulus(16, 4'hE, 1'b0);
        checkOutput({name, "_wr_cnt"}, wr_count - wr0, 1);
        checkOutput({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic readCheck(input string name, input logic [6:0] a, input logic [7:0] exp);
        tx_buf[0] = {1'b0, a};
        tx_buf[1] = 8'h00;
        applyStimulus(16, 4'hE, 1'b0);
        checkOutput(name, rx_buf[1], exp);
    endtask

    function automatic int countNonzero();
        int n = 0;
        for (int i = 0; i < 128; i++) begin
            if (dut.mem[i] !== 8'h00) n++;
        end
        return n;
    endfunction

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_miso"}, spi.miso_o, 0);
        checkOutput({name, "_miso_oe"}, spi.miso_oe_o, 0);
        checkOutput({name, "_wr_valid"}, wr_valid_o, 0);
        checkOutput({name, "_wr_addr"}, wr_addr_o, 0);
        checkOutput({name, "_wr_data"}, wr_data_o, 0);
        checkOutput({name, "_frame_err"}, frame_err_o, 0);
        checkOutput({name, "_mem_nonzero"}, countNonzero(), 0);
    endtask

    initial forever begin
        @(posedge pclk_i);
        cycle++;
    end

    // Scoreboard side: each write strobe pops the oldest expected write and checks its latency.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge pclk_i);
            if (wr_valid_o === 1'b1) begin
                wr_count++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", wr_addr_o, e.addr);
                    checkOutput("wr_data", wr_data_o, e.data);
                    checkOutput("wr_latency", cycle - last_rise_cycle, 4);
                end
            end
            if (frame_err_o === 1'b1) err_count++;
        end
    end

    initial begin
        vecs[0] = '{8'hD3, 8'h46, 4'hE, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{8'h53, 8'h00, 4'hE, 1'b1, 1'b0, 1'b1, 8'h46};
        vecs[2] = '{8'hD0, 8'hAA, 4'hD, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{8'h50, 8'h00, 4'hE, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{8'hA2, 8'h80, 4'hE, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[5] = '{8'h22, 8'h00, 4'hE, 1'b1, 1'b0, 1'b1, 8'h80};
        vecs[6] = '{8'h85, 8'h3C, 4'hE, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{8'h05, 8'h00, 4'hE, 1'b1, 1'b0, 1'b1, 8'h3C};
        vecs[8] = '{8'hF3, 8'hE1, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[9] = '{8'h73, 8'h00, 4'hE, 1'b1, 1'b0, 1'b1, 8'hE1};

        prst_i     = 1'b0;
        spi.sclk_i = 1'b0;
        spi.mosi_i = 1'b0;
        spi.cs_i   = 4'hF;
        repeat (5) @(negedge pclk_i);
        checkResetOutputs("por");
        prst_i = 1'b1;
        repeat (10) @(negedge pclk_i);

        for (int v = 0; v < 10; v++) begin
            wr0       = wr_count;
            err0      = err_count;
            tx_buf[0] = vecs[v].cmd;
            tx_buf[1] = vecs[v].data;
            if (vecs[v].is_wr && vecs[v].sel) expectWrite(vecs[v].cmd[6:0], vecs[v].data);
            applyStimulus(16, vecs[v].cs, 1'b0);
            checkOutput($sformatf("v%0d_oe_during", v), oe_during, vecs[v].sel);
            checkOutput($sformatf("v%0d_wr_cnt", v), wr_count - wr0, (vecs[v].is_wr && vecs[v].sel) ? 1 : 0);
            checkOutput($sformatf("v%0d_frame_err", v), err_count - err0, 0);
            checkOutput($sformatf("v%0d_oe_after", v), spi.miso_oe_o, 0);
            checkOutput($sformatf("v%0d_miso_after", v), spi.miso_o, 0);
            checkOutput($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
            if (vecs[v].chk_rd) checkOutput($sformatf("v%0d_read", v), rx_buf[1], vecs[v].exp_rd);
        end

        // Deselect after 11 bits: aborted write, then normal frames must still decode.
        wr0       = wr_count;
        err0      = err_count;
        tx_buf[0] = 8'hD4;
        tx_buf[1] = 8'h55;
        applyStimulus(11, 4'hE, 1'b0);
        checkOutput("abort_frame_err", err_count - err0, 1);
        checkOutput("abort_no_write", wr_count - wr0, 0);
        readCheck("abort_mem54", 7'h54, 8'h00);
        writeFrame("post_abort_wr", 7'h16, 8'h77);
        readCheck("post_abort_rd", 7'h16, 8'h77);

        // Three-byte frame crossing the top of the address space.
        wr0       = wr_count;
        err0      = err_count;
        tx_buf[0] = 8'hFF;
        tx_buf[1] = 8'h11;
        tx_buf[2] = 8'h22;
`ifdef SPI_SLV_AUTOINC_EN
        expectWrite(7'h7F, 8'h11);
        expectWrite(7'h00, 8'h22);
        applyStimulus(24, 4'hE, 1'b0);
        checkOutput("burst_wr_cnt", wr_count - wr0, 2);
        checkOutput("burst_frame_err", err_count - err0, 0);
        checkOutput("burst_last_miso", last_miso, 0);
        checkOutput("burst_sb_empty", exp_q.size(), 0);
        readCheck("burst_mem7f", 7'h7F, 8'h11);
        readCheck("burst_mem00", 7'h00, 8'h22);
`else
        expectWrite(7'h7F, 8'h11);
        applyStimulus(24, 4'hE, 1'b0);
        checkOutput("burst_wr_cnt", wr_count - wr0, 1);
        checkOutput("burst_frame_err", err_count - err0, 1);
        checkOutput("burst_read22_bit7", last_miso, 1);
        checkOutput("burst_sb_empty", exp_q.size(), 0);
        readCheck("burst_mem7f", 7'h7F, 8'h11);
        readCheck("burst_mem00", 7'h00, 8'h00);
        readCheck("burst_mem22", 7'h22, 8'h80);
`endif

        // Reset asserted five bits into a write frame with CS still low.
        writeFrame("pre_reset_wr", 7'h4C, 8'h99);
        err0      = err_count;
        wr0       = wr_count;
        tx_buf[0] = 8'h8A;
        tx_buf[1] = 8'h33;
        applyStimulus(5, 4'hE, 1'b1);
        prst_i = 1'b0;
        repeat (2) @(negedge pclk_i);
        checkResetOutputs("midrst");
        prst_i = 1'b1;
        repeat (8) @(negedge pclk_i);
        spi.cs_i = 4'hF;
        repeat (12) @(negedge pclk_i);
        checkOutput("midrst_no_frame_err", err_count - err0, 0);
        checkOutput("midrst_no_write", wr_count - wr0, 0);
        checkOutput("midrst_oe_idle", spi.miso_oe_o, 0);
        writeFrame("post_reset_wr", 7'h01, 8'h5A);
        readCheck("post_reset_mem01", 7'h01, 8'h5A);
        readCheck("post_reset_mem4c", 7'h4C, 8'h00);
        readCheck("post_reset_mem53", 7'h53, 8'h00);

        repeat (10) @(negedge pclk_i);
        checkOutput("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
